// File: rtl/edm_buf_pkg.sv
// Shared types and defaults for the receive buffer demultiplexer.
// State and queue-select encodings plus the effective-space helper.
package edm_buf_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_NET,
        S_MEM,
        S_DROP
    } state_t;

    typedef enum logic {
        Q_NET,
        Q_MEM
    } qsel_t;

    localparam int PAUSE_THRES_DEF = 3;

    // A write issued last cycle has not yet shown up in the space input.
    function automatic logic [2:0] eff_space(
        input logic [2:0] space,
        input logic       wr_prev
    );
        if (!wr_prev) return space;
        if (space == 3'd0) return 3'd0;
        return space - 3'd1;
    endfunction

endpackage

// File: rtl/rx_buf_demux_if.sv
// Receive-side beat input and queue-side write output bundle.
// master drives receive beats and queue levels, slave is the demux.
interface rx_buf_demux_if #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_sof;
    logic              rx_eof;
    logic              rx_is_mem;
    logic [2:0]        memq_space;
    logic [2:0]        netq_space;
    logic              memq_wr;
    logic              netq_wr;
    logic [DATA_W-1:0] q_data;
    logic              q_eof;
    logic              q_abort;
    logic              mem_pause;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  err_cnt;

    modport master (
        output rx_data, rx_valid, rx_sof, rx_eof, rx_is_mem,
        output memq_space, netq_space,
        input  memq_wr, netq_wr, q_data, q_eof, q_abort,
        input  mem_pause, drop_cnt, err_cnt
    );

    modport slave (
        input  rx_data, rx_valid, rx_sof, rx_eof, rx_is_mem,
        input  memq_space, netq_space,
        output memq_wr, netq_wr, q_data, q_eof, q_abort,
        output mem_pause, drop_cnt, err_cnt
    );

endinterface

// File: rtl/rx_buf_demux_sat_counter.sv
// Saturating event counter: +1 per cycle when inc, sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rx_buf_demux.sv
// Steers receive frames into the mem or net queue, dropping frames
// that find no room and closing broken frames with an abort beat.
module rx_buf_demux
    import edm_buf_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int PAUSE_THRES = PAUSE_THRES_DEF,
    parameter int CNT_W       = 16
) (
    input logic          clk,
    input logic          rst,
    rx_buf_demux_if.slave bus
);

    state_t            state;
    state_t            state_nx;
    qsel_t             sel;
    logic              full;
    logic              mem_full;
    logic              net_full;
    logic              wr;
    logic              eof_nx;
    logic              abort_nx;
    logic [DATA_W-1:0] data_nx;
    logic              drop_inc;
    logic              err_inc;

    logic              memq_wr;
    logic              netq_wr;
    logic [DATA_W-1:0] q_data;
    logic              q_eof;
    logic              q_abort;
    logic              mem_pause;

    assign mem_full = eff_space(bus.memq_space, memq_wr) == 3'd0;
    assign net_full = eff_space(bus.netq_space, netq_wr) == 3'd0;

    always_comb begin
        state_nx = state;
        wr       = 1'b0;
        eof_nx   = 1'b0;
        abort_nx = 1'b0;
        data_nx  = q_data;
        drop_inc = 1'b0;
        err_inc  = 1'b0;
        if (state == S_IDLE) begin
            sel = bus.rx_is_mem ? Q_MEM : Q_NET;
        end else begin
            sel = (state == S_MEM) ? Q_MEM : Q_NET;
        end
        full = (sel == Q_MEM) ? mem_full : net_full;

        if (bus.rx_valid) begin
            unique case (state)
                S_IDLE: begin
                    if (!bus.rx_sof) begin
                        err_inc = 1'b1;
                    end else if (full) begin
                        drop_inc = 1'b1;
                        state_nx = bus.rx_eof ? S_IDLE : S_DROP;
                    end else begin
                        wr      = 1'b1;
                        data_nx = bus.rx_data;
                        eof_nx  = bus.rx_eof;
                        if (bus.rx_eof) begin
                            state_nx = S_IDLE;
                        end else begin
                            state_nx = (sel == Q_MEM) ? S_MEM : S_NET;
                        end
                    end
                end
                S_NET, S_MEM: begin
                    // Broken or starved frame: close it with an abort beat.
                    if (bus.rx_sof || full) begin
                        wr       = 1'b1;
                        eof_nx   = 1'b1;
                        abort_nx = 1'b1;
                        data_nx  = '0;
                        err_inc  = bus.rx_sof;
                        drop_inc = !bus.rx_sof;
                        state_nx = bus.rx_eof ? S_IDLE : S_DROP;
                    end else begin
                        wr      = 1'b1;
                        data_nx = bus.rx_data;
                        eof_nx  = bus.rx_eof;
                        if (bus.rx_eof) state_nx = S_IDLE;
                    end
                end
                S_DROP: begin
                    err_inc = bus.rx_sof;
                    if (bus.rx_eof) state_nx = S_IDLE;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            memq_wr   <= 1'b0;
            netq_wr   <= 1'b0;
            q_data    <= '0;
            q_eof     <= 1'b0;
            q_abort   <= 1'b0;
            mem_pause <= 1'b0;
        end else begin
            state     <= state_nx;
            memq_wr   <= wr && (sel == Q_MEM);
            netq_wr   <= wr && (sel == Q_NET);
            q_data    <= data_nx;
            q_eof     <= eof_nx;
            q_abort   <= abort_nx;
            mem_pause <= int'(bus.memq_space) < PAUSE_THRES;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop_inc),
        .count (bus.drop_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc),
        .count (bus.err_cnt)
    );

    assign bus.memq_wr   = memq_wr;
    assign bus.netq_wr   = netq_wr;
    assign bus.q_data    = q_data;
    assign bus.q_eof     = q_eof;
    assign bus.q_abort   = q_abort;
    assign bus.mem_pause = mem_pause;

endmodule

// File: tb/tb_rx_buf_demux.sv
// Directed and random stimulus for rx_buf_demux against a frame-level
// model of its queue writes, pause flag and counters.
module tb_rx_buf_demux;

    localparam int DW   = 64;
    localparam int CW   = 4;
    localparam int PT   = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rx_buf_demux_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    rx_buf_demux #(
        .DATA_W      (DW),
        .PAUSE_THRES (PT),
        .CNT_W       (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model: frame context 0 none, 1 net frame, 2 mem frame, 3 discarding
    int          m_ctx = 0;
    int          m_drop = 0;
    int          m_err = 0;
    bit          m_wm = 0;
    bit          m_wn = 0;
    bit          m_eof = 0;
    bit          m_ab = 0;
    bit          m_pause = 0;
    logic [DW-1:0] m_data = '0;
    bit          m_data_chk = 0;
    int          n_mem_wr = 0;
    int          n_net_wr = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bump(inout int cnt);
        if (cnt < CMAX) cnt++;
    endtask

    task automatic emit(input bit to_mem, input logic [DW-1:0] d,
                        input bit eof, input bit ab);
        m_wm  = to_mem;
        m_wn  = !to_mem;
        m_eof = eof;
        m_ab  = ab;
        if (!ab) begin
            m_data     = d;
            m_data_chk = 1;
        end
    endtask

    task automatic model(input bit r, input bit v, input bit s,
                         input bit e, input bit im, input int ms,
                         input int ns, input logic [DW-1:0] d);
        int  room_m;
        int  room_n;
        int  room;
        bit  to_mem;
        room_m = ms - (m_wm ? 1 : 0);
        room_n = ns - (m_wn ? 1 : 0);
        if (room_m < 0) room_m = 0;
        if (room_n < 0) room_n = 0;
        m_wm = 0; m_wn = 0; m_eof = 0; m_ab = 0; m_data_chk = 0;
        if (r) begin
            m_ctx = 0; m_drop = 0; m_err = 0; m_pause = 0;
            m_data = '0; m_data_chk = 1;
            return;
        end
        m_pause = ms < PT;
        if (!v) return;
        if (m_ctx == 0) begin
            if (!s) begin
                bump(m_err);
            end else begin
                to_mem = im;
                room   = to_mem ? room_m : room_n;
                if (room == 0) begin
                    bump(m_drop);
                    m_ctx = e ? 0 : 3;
                end else begin
                    emit(to_mem, d, e, 0);
                    m_ctx = e ? 0 : (to_mem ? 2 : 1);
                end
            end
        end else if (m_ctx == 3) begin
            if (s) bump(m_err);
            if (e) m_ctx = 0;
        end else begin
            to_mem = (m_ctx == 2);
            room   = to_mem ? room_m : room_n;
            if (s) begin
                emit(to_mem, d, 1, 1);
                bump(m_err);
                m_ctx = e ? 0 : 3;
            end else if (room == 0) begin
                emit(to_mem, d, 1, 1);
                bump(m_drop);
                m_ctx = e ? 0 : 3;
            end else begin
                emit(to_mem, d, e, 0);
                if (e) m_ctx = 0;
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input bit s,
                        input bit e, input bit im, input int ms,
                        input int ns, input logic [DW-1:0] d);
        rst            = r;
        bus.rx_valid   = v;
        bus.rx_sof     = s;
        bus.rx_eof     = e;
        bus.rx_is_mem  = im;
        bus.memq_space = 3'(ms);
        bus.netq_space = 3'(ns);
        bus.rx_data    = d;
        model(r, v, s, e, im, ms, ns, d);
        @(posedge clk);
        #1;
        if (bus.memq_wr === 1'b1) n_mem_wr++;
        if (bus.netq_wr === 1'b1) n_net_wr++;
        chk("memq_wr", DW'(bus.memq_wr), DW'(m_wm));
        chk("netq_wr", DW'(bus.netq_wr), DW'(m_wn));
        chk("q_eof", DW'(bus.q_eof), DW'(m_eof));
        chk("q_abort", DW'(bus.q_abort), DW'(m_ab));
        chk("mem_pause", DW'(bus.mem_pause), DW'(m_pause));
        chk("drop_cnt", DW'(bus.drop_cnt), DW'(m_drop));
        chk("err_cnt", DW'(bus.err_cnt), DW'(m_err));
        if (m_data_chk) chk("q_data", bus.q_data, m_data);
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        logic [DW-1:0] d;
        int            ms;
        int            ns;

        // Reset state
        step(1, 0, 0, 0, 0, 7, 7, '0);
        step(1, 1, 1, 1, 1, 0, 0, rnd64());

        // 4-beat net frame with plenty of room
        n_mem_wr = 0; n_net_wr = 0;
        step(0, 1, 1, 0, 0, 7, 7, rnd64());
        step(0, 1, 0, 0, 0, 7, 7, rnd64());
        step(0, 1, 0, 0, 0, 7, 7, rnd64());
        step(0, 1, 0, 1, 0, 7, 7, rnd64());
        chk("net4_eof", DW'(bus.q_eof), DW'(1));
        step(0, 0, 0, 0, 0, 7, 7, '0);
        chk("net4_writes", DW'(n_net_wr), DW'(4));
        chk("net4_memwr", DW'(n_mem_wr), DW'(0));

        // Single-beat mem frame with exactly one free entry
        step(0, 1, 1, 1, 1, 1, 7, rnd64());
        chk("mem1_wr", DW'(bus.memq_wr), DW'(1));
        chk("mem1_eof", DW'(bus.q_eof), DW'(1));
        step(0, 1, 1, 1, 0, 7, 7, rnd64());
        chk("mem1_idle", DW'(bus.netq_wr), DW'(1));

        // Mem frame arriving to a full queue is dropped whole
        step(1, 0, 0, 0, 0, 7, 7, '0);
        step(0, 1, 1, 0, 1, 0, 7, rnd64());
        step(0, 1, 0, 0, 1, 7, 7, rnd64());
        step(0, 1, 0, 0, 1, 7, 7, rnd64());
        step(0, 1, 0, 1, 1, 7, 7, rnd64());
        chk("drop_one", DW'(bus.drop_cnt), DW'(1));
        step(0, 1, 1, 1, 1, 7, 7, rnd64());
        chk("drop_back_idle", DW'(bus.memq_wr), DW'(1));

        // New sof inside a net frame aborts it
        step(1, 0, 0, 0, 0, 7, 7, '0);
        step(0, 1, 1, 0, 0, 7, 7, rnd64());
        step(0, 1, 1, 0, 0, 7, 7, rnd64());
        chk("sof_abort", DW'(bus.q_abort), DW'(1));
        chk("sof_err", DW'(bus.err_cnt), DW'(1));
        step(0, 1, 0, 1, 0, 7, 7, rnd64());
        chk("sof_drop_nowr", DW'(bus.netq_wr), DW'(0));

        // Room consumed by last cycle's write starves the next beat
        step(1, 0, 0, 0, 0, 7, 7, '0);
        step(0, 1, 1, 0, 0, 7, 1, rnd64());
        step(0, 1, 0, 0, 0, 7, 1, rnd64());
        chk("starve_abort", DW'(bus.q_abort), DW'(1));
        chk("starve_drop", DW'(bus.drop_cnt), DW'(1));
        step(0, 1, 0, 1, 0, 7, 7, rnd64());

        // Pause threshold crossing
        step(0, 0, 0, 0, 0, 4, 7, '0);
        chk("pause_4", DW'(bus.mem_pause), DW'(0));
        step(0, 0, 0, 0, 0, 2, 7, '0);
        chk("pause_2", DW'(bus.mem_pause), DW'(1));
        step(0, 0, 0, 0, 0, 3, 7, '0);
        chk("pause_3", DW'(bus.mem_pause), DW'(0));

        // Reset mid frame, continuation beats are stray
        step(0, 1, 1, 0, 0, 7, 7, rnd64());
        step(0, 1, 0, 0, 0, 7, 7, rnd64());
        step(1, 0, 0, 0, 0, 7, 7, '0);
        chk("rst_netwr", DW'(bus.netq_wr), DW'(0));
        n_net_wr = 0;
        step(0, 1, 0, 0, 0, 7, 7, rnd64());
        step(0, 1, 0, 1, 0, 7, 7, rnd64());
        chk("rst_stray_err", DW'(bus.err_cnt), DW'(2));
        chk("rst_no_netwr", DW'(n_net_wr), DW'(0));

        // Counter saturation
        for (int i = 0; i < CMAX + 5; i++) step(0, 1, 0, 0, 0, 7, 7, '0);
        chk("err_sat", DW'(bus.err_cnt), DW'(CMAX));

        // Randomised traffic
        step(1, 0, 0, 0, 0, 7, 7, '0);
        for (int i = 0; i < 4000; i++) begin
            d  = rnd64();
            ms = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7)
                                             : $urandom_range(0, 2);
            ns = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7)
                                             : $urandom_range(0, 2);
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 4) != 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0,
                 1'($urandom_range(0, 1)),
                 ms, ns, d);
            checks++;
            assert (!(bus.memq_wr && bus.netq_wr)) else begin
                errors++;
                $error("FAIL both_wr observed=1 expected=0");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_buf_demux.md
RX_BUF_DEMUX -- requirements
Module: rx_buf_demux

Interface
REQ-001 SHALL have parameter DATA_W, default 64, receive beat width in bits.
REQ-002 SHALL have parameter PAUSE_THRES, default 3, memq_space level below which mem_pause asserts.
REQ-003 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port rx_data, input, DATA_W: receive beat from the XGMII RX decoder.
REQ-007 SHALL have port rx_valid, input, 1: rx_data is valid this cycle.
REQ-008 SHALL have port rx_sof / rx_eof, input, 1 each: first / last beat of a frame; both high means a single-beat frame.
REQ-009 SHALL have port rx_is_mem, input, 1: frame arrived in the IPG memory channel; 0 means network frame; meaningful only with rx_sof.
REQ-010 SHALL have ports memq_space / netq_space, input, 3 each: free entries in the mem / net queue.
REQ-011 SHALL have ports memq_wr / netq_wr, output, 1 each: write strobe to the mem / net queue.
REQ-012 SHALL have ports q_data (DATA_W), q_eof (1), q_abort (1), output: shared write data, last-beat flag and partial-frame abort flag.
REQ-013 SHALL have port mem_pause, output, 1: backpressure request to the link peer's memory sender.
REQ-014 SHALL have ports drop_cnt / err_cnt, output, CNT_W each: dropped-frame and protocol-error counts.

Function
REQ-015 SHALL implement states IDLE, NET, MEM and DROP; all outputs SHALL be registered, with one cycle of latency from rx beat to queue write.
REQ-016 SHALL hold state and issue no write in any cycle with rx_valid=0.
REQ-017 SHALL compute the effective space of a queue as its space input minus 1 if a write to that queue was issued in the previous cycle, otherwise as the space input.
REQ-018 SHALL, in IDLE with valid&sof, select the mem queue when rx_is_mem=1 and the net queue otherwise.
  - If the selected queue's effective space is 0: no write, drop_cnt+1, next state DROP (or IDLE if eof).
  - Otherwise: write the beat, q_eof=rx_eof, next state MEM or NET (or IDLE if eof).
REQ-019 SHALL, in IDLE with valid&!sof, discard the beat and increment err_cnt (stray beat).
REQ-020 SHALL, in NET/MEM with valid&!sof and effective space >=1, write the beat to the active queue; on eof, set q_eof=1 and go to IDLE.
REQ-021 SHALL, in NET/MEM with valid&!sof and effective space 0, write an abort beat to the active queue (q_eof=1, q_abort=1, data don't-care), increment drop_cnt and go to DROP.
REQ-022 SHALL, in NET/MEM with valid&sof (new frame before eof), write an abort beat to the active queue, increment err_cnt, discard the new beat and go to DROP (or IDLE if eof).
REQ-023 SHALL, in DROP, discard beats until valid&eof, then go to IDLE; a sof seen in DROP SHALL increment err_cnt and keep the state DROP.
REQ-024 SHALL never assert memq_wr and netq_wr in the same cycle; q_abort SHALL be high only together with q_eof and a write strobe.
REQ-025 SHALL register mem_pause as (memq_space < PAUSE_THRES) every cycle, independent of state.
REQ-026 SHALL saturate drop_cnt and err_cnt at all-ones; each SHALL increment by at most 1 per cycle.

Reset
REQ-027 SHALL, with rst high at a clock edge, set the state to IDLE, memq_wr, netq_wr, q_eof, q_abort and mem_pause to 0, q_data to 0, and both counters to 0; rst takes priority over all inputs.
REQ-028 SHALL treat the continuation beats of a frame interrupted by reset as stray beats per REQ-019, and SHALL emit no abort for the interrupted frame.

Structure
REQ-029 SHALL take the state enumeration, queue-select encoding and the default PAUSE_THRES from shared package edm_buf_pkg.
REQ-030 SHALL instantiate sub-module sat_counter (parameter CNT_W; ports clk, rst, inc, count) twice, for drop_cnt and err_cnt.

Verification
REQ-031 SHALL cover: net frame of 4 beats, netq_space=7 -> netq_wr high 4 cycles, starting 1 cycle after the sof beat, q_eof on the 4th; memq_wr stays 0.
REQ-032 SHALL cover: mem single-beat frame (sof=eof=1, rx_is_mem=1), memq_space=1 -> one memq_wr with q_eof=1; next state IDLE.
REQ-033 SHALL cover: mem frame sof with memq_space=0 -> no write, drop_cnt=1, 3 following beats discarded, back to IDLE after eof.
REQ-034 SHALL cover: net frame of 3 beats whose 2nd beat carries sof -> abort beat to net queue (q_eof=1, q_abort=1), err_cnt=1, state DROP.
REQ-035 SHALL cover: memq_space stepped 4->2->3 -> mem_pause 0, then 1, then 0, each one cycle later.
REQ-036 SHALL cover: rst pulsed mid net frame, then 2 non-sof beats -> all outputs 0, err_cnt=2, no netq_wr.
